// File: rtl/fsmd_seq_alu.sv
// fsmd_seq_alu: FSM+datapath reducing operands a..e into R3 (a+b+c+d+e or a+b-c-d+e); FSMD_OVF_EN adds a sticky ovf output.
module fsmd_seq_alu #(
  parameter int WIDTH     = 4,
  parameter int HOLD_DONE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [2:0]       PS,
  output logic [2:0]       NS
`ifdef FSMD_OVF_EN
  ,
  output logic             ovf
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, S_AB, S_C, S_D, S_E, DONE, ILL} state_t;
  state_t ps, ns;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q, e_q;
  logic mode_q;
  logic [WIDTH:0] alu;
  // Top bit is carry for add and borrow for subtract
  assign alu = (mode_q && (ps == S_C || ps == S_D)) ? {1'b0, R1} - {1'b0, R2} : {1'b0, R1} + {1'b0, R2};
  assign busy = ps != IDLE;
  assign done = ps == DONE;
  assign PS = ps;
  assign NS = ns;
  always_comb begin
    ns = IDLE;
    case (ps)
      IDLE:    ns = start ? LOAD : IDLE;
      LOAD:    ns = S_AB;
      S_AB:    ns = S_C;
      S_C:     ns = S_D;
      S_D:     ns = S_E;
      S_E:     ns = DONE;
      DONE:    ns = (HOLD_DONE != 0 && start) ? DONE : IDLE;
      default: ns = IDLE;
    endcase
    if (reset) ns = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ps <= IDLE;
      R1 <= '0;
      R2 <= '0;
      R3 <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      e_q <= '0;
      mode_q <= 1'b0;
    end else begin
      ps <= ns;
      case (ps)
        IDLE: if (start) begin
          a_q <= a;
          b_q <= b;
          c_q <= c;
          d_q <= d;
          e_q <= e;
          mode_q <= mode;
        end
        LOAD: begin
          R1 <= a_q;
          R2 <= b_q;
        end
        S_AB: begin
          R1 <= alu[WIDTH-1:0];
          R2 <= c_q;
        end
        S_C: begin
          R1 <= alu[WIDTH-1:0];
          R2 <= d_q;
        end
        S_D: begin
          R1 <= alu[WIDTH-1:0];
          R2 <= e_q;
        end
        S_E: R3 <= alu[WIDTH-1:0];
        default: ;
      endcase
    end
  end
`ifdef FSMD_OVF_EN
  always_ff @(posedge clock) begin
    if (reset) ovf <= 1'b0;
    else if (ps == LOAD) ovf <= 1'b0;
    else if (ps == S_AB || ps == S_C || ps == S_D || ps == S_E) ovf <= ovf | alu[WIDTH];
  end
`else
  logic unused_carry;
  assign unused_carry = alu[WIDTH];
`endif
endmodule
